// File: rtl/sd_load_pkg.sv
// Shared definitions for the SD load scheduler.
//   state_t      : scheduler FSM states
//   job_t        : queued job descriptor (start sector, sector count, DDR byte base)
//   SECTOR_BYTES : bytes per SD sector, used to advance the DDR address per chunk
package sd_load_pkg;

  localparam int unsigned SECTOR_BYTES = 512;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_INIT = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] sec;
    logic [31:0] num;
    logic [31:0] addr;
  } job_t;

endpackage

// File: rtl/sd_load_scheduler_if.sv
// Job push channel into the SD load scheduler.
// Handshake: the producer drives job_valid with job_sec/job_num/job_addr stable;
// the consumer drives job_ready. A job transfers on every rising clock edge
// where job_valid && job_ready. job_ready never depends on job_valid.
//   master : job producer
//   slave  : scheduler
interface sd_load_scheduler_if;

  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_sec;
  logic [31:0] job_num;
  logic [31:0] job_addr;

  modport master (
    output job_valid, job_sec, job_num, job_addr,
    input  job_ready
  );

  modport slave (
    input  job_valid, job_sec, job_num, job_addr,
    output job_ready
  );

endinterface

// File: rtl/sd_job_fifo.sv
// Job descriptor FIFO for the SD load scheduler.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, din    : write din when push && !full
//   pop, dout    : dout is the head entry; pop && !empty discards it
//   full, empty  : occupancy flags
// Push and pop in the same cycle both take effect.
module sd_job_fifo
  import sd_load_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  job_t din,
  input  logic pop,
  output job_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two in 2..16");
  end

  job_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sd_load_scheduler.sv
// SD load scheduler: queues load jobs and splits each into loader chunks of at
// most MAX_CHUNK sectors, issuing one ld_start pulse per chunk.
// Ports:
//   sys_clk, rst_n        : clock, asynchronous active-low reset
//   job (slave)           : job push channel (job_valid/job_ready, sec/num/addr)
//   ld_init_done          : SD card initialised (level)
//   ld_start              : one-cycle chunk start pulse
//   ld_sec/ld_num/ld_addr : current chunk, stable from ld_start until ld_done
//   ld_done               : loader completion level; rising edge counts
//   busy                  : queue non-empty or FSM not idle
//   jobs_done             : completed job counter (wraps)
//   err                   : sticky watchdog timeout
//   dbg_state             : current FSM state
// Build option: define SD_LOAD_SCHED_WATCHDOG_EN to enable the WAIT_DONE
// watchdog (TIMEOUT_CYC cycles); otherwise err is tied low.
module sd_load_scheduler
  import sd_load_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int MAX_CHUNK   = 64,
  parameter int TIMEOUT_CYC = 1 << 24
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  sd_load_scheduler_if.slave   job,
  input  logic                 ld_init_done,
  output logic                 ld_start,
  output logic [31:0]          ld_sec,
  output logic [31:0]          ld_num,
  output logic [31:0]          ld_addr,
  input  logic                 ld_done,
  output logic                 busy,
  output logic [15:0]          jobs_done,
  output logic                 err,
  output state_t               dbg_state
);

  if ((MAX_CHUNK < 1) || (MAX_CHUNK > 65535)) begin : g_bad_chunk
    $error("MAX_CHUNK must be in 1..65535");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be positive");
  end

  localparam logic [31:0] MAX_CHUNK_W = 32'(MAX_CHUNK);

  state_t      state_q, state_d;
  logic [31:0] sec_q, sec_d, rem_q, rem_d, addr_q, addr_d;
  logic [31:0] chunk;
  logic [15:0] jobs_q, jobs_d;
  logic        ready_en_q;
  logic        ld_done_q;
  logic        done_edge;
  logic        push, pop;
  logic        fifo_full, fifo_empty;
  logic        wd_fire;
  job_t        head, push_job;

  // job_ready stays low until the first clock after reset release.
  assign job.job_ready = ready_en_q && !fifo_full;
  assign push          = job.job_valid && job.job_ready;
  assign push_job      = '{sec: job.job_sec, num: job.job_num, addr: job.job_addr};

  sd_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_job),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign chunk     = (rem_q < MAX_CHUNK_W) ? rem_q : MAX_CHUNK_W;
  // ld_done_q follows ld_done every cycle, so a level already high while in
  // ISSUE is seen as old on entry to WAIT_DONE and does not count as an edge.
  assign done_edge = ld_done && !ld_done_q;

  assign ld_sec    = sec_q;
  assign ld_num    = chunk;
  assign ld_addr   = addr_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);
  assign jobs_done = jobs_q;
  assign dbg_state = state_q;

`ifdef SD_LOAD_SCHED_WATCHDOG_EN
  logic [31:0] wd_cnt_q;
  logic        err_q;

  // Counter restarts on every entry to WAIT_DONE; a ld_done edge in the
  // limit cycle wins over the timeout.
  assign wd_fire = (state_q == ST_WAIT_DONE) && !done_edge &&
                   (wd_cnt_q == 32'(TIMEOUT_CYC - 1));
  assign err     = err_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ST_WAIT_DONE) wd_cnt_q <= wd_cnt_q + 32'd1;
      else                         wd_cnt_q <= '0;
      if (wd_fire) err_q <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    sec_d    = sec_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    jobs_d   = jobs_q;
    pop      = 1'b0;
    ld_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head.num == '0) begin
            // Empty job completes without touching the loader.
            pop    = 1'b1;
            jobs_d = jobs_q + 16'd1;
          end else begin
            sec_d   = head.sec;
            rem_d   = head.num;
            addr_d  = head.addr;
            state_d = ST_WAIT_INIT;
          end
        end
      end
      ST_WAIT_INIT: begin
        if (ld_init_done) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        ld_start = 1'b1;
        state_d  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done_edge) begin
          sec_d  = sec_q + chunk;
          addr_d = addr_q + chunk * 32'(SECTOR_BYTES);
          rem_d  = rem_q - chunk;
          if (rem_q == chunk) begin
            pop     = 1'b1;
            jobs_d  = jobs_q + 16'd1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else if (wd_fire) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sec_q      <= '0;
      rem_q      <= '0;
      addr_q     <= '0;
      jobs_q     <= '0;
      ready_en_q <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      jobs_q     <= jobs_d;
      ready_en_q <= 1'b1;
      ld_done_q  <= ld_done;
    end
  end

endmodule

// File: tb/tb_sd_load_scheduler.sv
// Bench for sd_load_scheduler: directed scenarios plus random jobs, with the
// expected chunk sequence derived from sector arithmetic on queued jobs.
module tb_sd_load_scheduler;
  import sd_load_pkg::*;

  localparam int DEPTH       = 4;
  localparam int MAX_CHUNK   = 64;
  localparam int TIMEOUT_CYC = 100;
  localparam int W           = 96;

  // ---------------- clock / reset ----------------
  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_init_done = 1'b0;
  logic        ld_done = 1'b0;
  logic        ld_start;
  logic [31:0] ld_sec, ld_num, ld_addr;
  logic        busy;
  logic [15:0] jobs_done;
  logic        err;
  state_t      dbg_state;

  always #5 sys_clk = ~sys_clk;

  sd_load_scheduler_if job_bus ();

  sd_load_scheduler #(
    .DEPTH       (DEPTH),
    .MAX_CHUNK   (MAX_CHUNK),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .job          (job_bus),
    .ld_init_done (ld_init_done),
    .ld_start     (ld_start),
    .ld_sec       (ld_sec),
    .ld_num       (ld_num),
    .ld_addr      (ld_addr),
    .ld_done      (ld_done),
    .busy         (busy),
    .jobs_done    (jobs_done),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [W-1:0] exp_q[$];
  int unsigned exp_jobs = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All sampling and driving happens 1ns after a rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_job(input logic [31:0] s, input logic [31:0] n, input logic [31:0] a);
    int t;
    t = 0;
    job_bus.job_valid = 1'b1;
    job_bus.job_sec   = s;
    job_bus.job_num   = n;
    job_bus.job_addr  = a;
    while (!job_bus.job_ready && t < 200) begin
      step();
      t++;
    end
    check("push_ready_seen", job_bus.job_ready, 1'b1);
    step();
    job_bus.job_valid = 1'b0;
    exp_q.push_back({s, n, a});
  endtask

  task automatic wait_start();
    int t;
    t = 0;
    while (!ld_start && t < 300) begin
      step();
      t++;
    end
    check("ld_start_seen", ld_start, 1'b1);
  endtask

  // Loader responder for one expected chunk.
  task automatic serve_chunk(input logic [31:0] s, input logic [31:0] n,
                             input logic [31:0] a, input bit more);
    int d;
    wait_start();
    check("ld_sec", ld_sec, s);
    check("ld_num", ld_num, n);
    check("ld_addr", ld_addr, a);
    step();
    check("start_pulse_width", ld_start, 1'b0);
    d = $urandom_range(0, 3);
    for (int i = 0; i < d; i++) begin
      step();
      check("no_early_start", ld_start, 1'b0);
      check("ld_num_hold", ld_num, n);
    end
    if (ld_done) begin
      // Level left high from the previous chunk must not have counted.
      ld_done = 1'b0;
      step();
      check("primed_no_start", ld_start, 1'b0);
    end
    ld_done = 1'b1;
    step();
    if (more) begin
      check("restart_latency", ld_start, 1'b1);
      if ($urandom_range(0, 1) == 0) ld_done = 1'b0;
    end else begin
      exp_jobs++;
      check("jobs_done", jobs_done, 16'(exp_jobs));
      ld_done = 1'b0;
    end
  endtask

  // Reference model: split the oldest queued job into chunks.
  task automatic run_next_job();
    logic [W-1:0] j;
    logic [31:0]  s, r, a, c;
    int           t;
    bit           seen;
    if (exp_q.size() == 0) return;
    j = exp_q.pop_front();
    {s, r, a} = j;
    if (r == 0) begin
      exp_jobs++;
      t = 0;
      seen = ld_start;
      while (jobs_done !== 16'(exp_jobs) && t < 20) begin
        step();
        if (ld_start) seen = 1'b1;
        t++;
      end
      check("zero_job_done", jobs_done, 16'(exp_jobs));
      check("zero_job_no_start", seen, 1'b0);
    end else begin
      while (r != 0) begin
        c = (r < 32'(MAX_CHUNK)) ? r : 32'(MAX_CHUNK);
        serve_chunk(s, c, a, r != c);
        s = s + c;
        a = a + c * 32'd512;
        r = r - c;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] s, n, a;
    job_bus.job_valid = 1'b0;
    job_bus.job_sec   = '0;
    job_bus.job_num   = '0;
    job_bus.job_addr  = '0;

    // Reset values
    step(); step(); step();
    check("rst_ld_start", ld_start, 1'b0);
    check("rst_ld_sec", ld_sec, 32'd0);
    check("rst_ld_num", ld_num, 32'd0);
    check("rst_ld_addr", ld_addr, 32'd0);
    check("rst_jobs_done", jobs_done, 16'd0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_job_ready", job_bus.job_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check("ready_before_first_clk", job_bus.job_ready, 1'b0);
    step();
    check("ready_after_first_clk", job_bus.job_ready, 1'b1);

    // Single short job
    ld_init_done = 1'b1;
    push_job(32'd100, 32'd10, 32'h1000);
    check("busy_single", busy, 1'b1);
    run_next_job();
    check("idle_after_single", busy, 1'b0);

    // Multi-chunk job: 64/64/22
    push_job(32'd100, 32'd150, 32'h1000);
    run_next_job();
    check("idle_after_multi", busy, 1'b0);

    // Init gating
    ld_init_done = 1'b0;
    push_job(32'd7, 32'd3, 32'h200);
    for (int i = 0; i < 8; i++) begin
      step();
      check("init_low_no_start", ld_start, 1'b0);
    end
    ld_init_done = 1'b1;
    step();
    check("init_to_start", ld_start, 1'b1);
    run_next_job();

    // Five jobs into a four-deep queue
    ld_init_done = 1'b0;
    for (int i = 0; i < 4; i++)
      push_job($urandom, 32'($urandom_range(1, 100)), $urandom);
    s = $urandom; n = 32'($urandom_range(1, 100)); a = $urandom;
    job_bus.job_valid = 1'b1;
    job_bus.job_sec   = s;
    job_bus.job_num   = n;
    job_bus.job_addr  = a;
    for (int i = 0; i < 3; i++) begin
      check("full_ready_low", job_bus.job_ready, 1'b0);
      step();
    end
    ld_init_done = 1'b1;
    run_next_job();
    check("ready_after_pop", job_bus.job_ready, 1'b1);
    step();
    job_bus.job_valid = 1'b0;
    exp_q.push_back({s, n, a});
    for (int i = 0; i < 4; i++) run_next_job();
    check("idle_after_five", busy, 1'b0);

    // Zero-length job, then a normal one queued behind another zero
    push_job(32'd55, 32'd0, 32'h40);
    run_next_job();
    push_job(32'd1, 32'd0, 32'h0);
    push_job(32'd2, 32'd65, 32'hFFFF_FE00);
    run_next_job();
    run_next_job();

    // Random jobs
    for (int k = 0; k < 8; k++) begin
      n = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 200));
      push_job($urandom, n, $urandom);
      run_next_job();
    end
    check("idle_after_random", busy, 1'b0);

    // Reset mid-operation abandons queued work
    ld_init_done = 1'b0;
    push_job(32'd10, 32'd5, 32'h0);
    push_job(32'd20, 32'd5, 32'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ld_init_done = 1'b1;
    exp_q.delete();
    exp_jobs = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_reset_no_start", ld_start, 1'b0);
    end
    check("post_reset_busy", busy, 1'b0);
    check("post_reset_jobs", jobs_done, 16'd0);
    push_job(32'd1, 32'd1, 32'h0);
    run_next_job();

`ifdef SD_LOAD_SCHED_WATCHDOG_EN
    // Loader never completes: watchdog abandons the job
    push_job(32'd9, 32'd5, 32'h0);
    wait_start();
    for (int i = 0; i < TIMEOUT_CYC; i++) step();
    check("wd_err_before_limit", err, 1'b0);
    step();
    check("wd_err_at_limit", err, 1'b1);
    check("wd_jobs_unchanged", jobs_done, 16'(exp_jobs));
    void'(exp_q.pop_front());
    push_job(32'd300, 32'd2, 32'h4000);
    run_next_job();
    check("wd_err_sticky", err, 1'b1);
`else
    check("err_tied_low", err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
